square_seq32: RTL and testbench

- Sequential radix-2 shift-and-add squarer.
- Computes O = A*A for an unsigned WIDTH-bit operand and returns a 2*WIDTH-bit result.
- Forward direction of the square-root path: produces y^2 from y, used to generate and check square-root operands with a fraction of the area of a combinational MULT32.
- Valid/ready handshake on both the input and output sides.

---
 rtl/square_seq32.sv | 119 +++++++++++
 tb/tb_square_seq32.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/square_seq32.sv
// Sequential shift-and-add squarer O = A*A; SQUARE_SEQ_EARLY_TERM_EN stops once the multiplier empties.
// Latency: WIDTH edges after accept (early-term: max(1, floor(log2 A)+1)); no overlap between operands.
// Backpressure: in_ready only in IDLE; O/out_valid hold in DONE until out_ready.
module square_seq32 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   O,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               last_iter;

  always_comb begin
    acc_sum = mplier[0] ? (acc + mcand) : acc;
  end

`ifdef SQUARE_SEQ_EARLY_TERM_EN
  // Finish when no set bits remain above the one consumed this edge; the
  // counter term can never fire first but bounds the loop regardless.
  always_comb begin
    last_iter = (mplier[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));
  end
`else
  always_comb begin
    last_iter = (cnt == CW'(WIDTH - 1));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      O      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= A;
            cnt    <= '0;
          end
        end
        BUSY: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // O is only rewritten on entry to DONE, so it keeps the last result afterwards.
          if (last_iter) begin
            O <= acc_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_seq32.sv
// Scoreboard bench for square_seq32: driver pushes model results, monitor pops on output handshakes.
module tb_square_seq32;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   A = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] O;
  logic           out_valid;
  logic           out_ready = 1'b0;

  square_seq32 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .O         (O),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [2*W-1:0] o;
    int             e;
    int             lat;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: edges from accept to result, from the operand's highest set bit.
  function automatic int lat_of(input logic [W-1:0] a);
`ifdef SQUARE_SEQ_EARLY_TERM_EN
    int msb = 0;
    for (int i = 0; i < W; i++) if (a[i]) msb = i + 1;
    return (msb == 0) ? 1 : msb;
`else
    return W;
`endif
  endfunction

  function automatic logic [2*W-1:0] sq_of(input logic [W-1:0] a);
    logic [2*W-1:0] x;
    x = {{W{1'b0}}, a};
    return x * x;
  endfunction

  // Monitor: compare O every cycle it is presented, latency on the rising cycle.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        if (!prev_v) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: O=0x%0h presented with nothing outstanding (cycle %0d)", O, cyc);
        end
      end else begin
        check("result", O, q[0].o);
        if (!prev_v) check("latency", 64'(cyc - q[0].e), 64'(q[0].lat));
        if (out_ready) void'(q.pop_front());
      end
    end
    prev_v = out_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] a, input bit hold, output int e);
    int   n;
    exp_t x;
    n = 0;
    e = -1;
    in_valid = 1'b1;
    A = a;
    while (e < 0 && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        e = cyc + 1;
        x.o = sq_of(a);
        x.e = e;
        x.lat = lat_of(a);
        q.push_back(x);
      end
      n++;
    end
    if (e < 0) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: operand 0x%0h never accepted", a);
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    check("in_ready_after_accept", 64'(in_ready), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
    end
    check("in_ready_idle", 64'(in_ready), 64'd1);
  endtask

  logic [W-1:0] dir_ops [6] = '{32'h3, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0, 32'h5, 32'h8000_0000};

  initial begin
    int e, e1, e2, n;
    logic [W-1:0] a;

    tick(2);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_O", O, 64'd0);
    tick(1);

    // Directed operands including both extremes.
    foreach (dir_ops[i]) begin
      out_ready = 1'b0;
      send(dir_ops[i], 1'b0, e);
      drain();
    end
    check("O_retained", O, 64'h4000_0000_0000_0000);

    // Backpressure: hold the result, try to push another operand meanwhile.
    out_ready = 1'b0;
    send(32'd12, 1'b0, e);
    n = 0;
    while (!out_valid && n < 100) begin
      tick(1);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      A = 32'd7;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_O", O, 64'h90);
      tick(1);
    end
    in_valid = 1'b0;
    drain();

    // Reset during BUSY: rst sampled at accept edge + 10.
    out_ready = 1'b0;
    send(32'h1234, 1'b0, e);
    tick(9);
    rst = 1'b1;
    q.delete();
    tick(1);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", 64'(in_ready), 64'd1);
    tick(40);
    check("midrst_no_output", 64'(out_valid), 64'd0);
    send(32'd2, 1'b0, e);
    drain();

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    send(32'd100, 1'b1, e1);
    send(32'd65535, 1'b1, e2);
    in_valid = 1'b0;
    check("b2b_accept_spacing", 64'(e2 - e1), 64'(lat_of(32'd100) + 2));
    drain();

    // Randomized operands of varied magnitude and consumer readiness.
    for (int i = 0; i < 24; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      out_ready = 1'($urandom_range(0, 1));
      send(a, 1'b0, e);
      tick($urandom_range(0, 3));
      drain();
    end

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
